hilbert_mac_scheduler: RTL

HILBERT_MAC_SCHEDULER -- requirements
Module: hilbert_mac_scheduler

---
 rtl/hilbert_mac_scheduler.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/hilbert_mac_scheduler.sv
// hilbert_mac_scheduler
// Time-multiplexed Hilbert-pair FIR: one shared signed NUM_BITS x NUM_BITS
// multiplier alternates between the cos (Hilbert) bank and the sin (delay)
// bank for every tap. A sample takes IDLE -> MAC (2*COEFF_LENGTH cycles) ->
// OUTPUT -> IDLE, and the results appear with done_o one cycle later.
//
// Ports
//   clk_i, reset_i       clock, asynchronous active-high reset
//   tick_i, signal_i     sample strobe and signed sample
//   coeff_we_i/sel_i/addr_i/data_i  coefficient write port (sel 0=cos, 1=sin)
//   sin_o, cos_o         registered filtered results
//   done_o               one-cycle pulse when sin_o/cos_o update
//   busy_o               high while a sample is in MAC or OUTPUT
//   overrun_o            sticky, a tick arrived while not idle
//   coeff_err_o          sticky, a coefficient write was rejected
//
// Build option: define HILBERT_SATURATE_EN to clamp results to the NUM_BITS
// range; otherwise the low NUM_BITS bits are kept (wrap).
module hilbert_mac_scheduler #(
    parameter int NUM_BITS     = 24,
    parameter int COEFF_LENGTH = 13
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            tick_i,
    input  logic signed [NUM_BITS-1:0]      signal_i,
    input  logic                            coeff_we_i,
    input  logic                            coeff_sel_i,
    input  logic [$clog2(COEFF_LENGTH)-1:0] coeff_addr_i,
    input  logic signed [NUM_BITS-1:0]      coeff_data_i,
    output logic signed [NUM_BITS-1:0]      sin_o,
    output logic signed [NUM_BITS-1:0]      cos_o,
    output logic                            done_o,
    output logic                            busy_o,
    output logic                            overrun_o,
    output logic                            coeff_err_o
);
    localparam int ADDR_W = $clog2(COEFF_LENGTH);
    localparam int PROD_W = 2 * NUM_BITS;
    localparam int ACC_W  = PROD_W + ADDR_W;
    localparam logic [ADDR_W:0]   LEN_C  = (ADDR_W + 1)'(COEFF_LENGTH);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(COEFF_LENGTH - 1);
    localparam logic [ADDR_W-1:0] ONE_C  = ADDR_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MAC    = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    // Q1.(N-1) scaling back to N bits: floor shift, then clamp or wrap.
    function automatic logic signed [NUM_BITS-1:0] reduce_acc(input logic signed [ACC_W-1:0] acc);
        logic signed [NUM_BITS-1:0] result;
`ifdef HILBERT_SATURATE_EN
        logic signed [ACC_W-1:0] shifted;
        logic signed [ACC_W-1:0] max_v;
        logic signed [ACC_W-1:0] min_v;
        shifted = acc >>> (NUM_BITS - 1);
        max_v   = {{(ACC_W - NUM_BITS + 1){1'b0}}, {(NUM_BITS - 1){1'b1}}};
        min_v   = ~max_v;
        if (shifted > max_v) begin
            result = max_v[NUM_BITS-1:0];
        end else if (shifted < min_v) begin
            result = min_v[NUM_BITS-1:0];
        end else begin
            result = shifted[NUM_BITS-1:0];
        end
`else
        result = NUM_BITS'(acc >>> (NUM_BITS - 1));
`endif
        return result;
    endfunction

    logic [1:0]                 state_q, state_d;
    logic [ADDR_W-1:0]          k_q;
    logic                       phase_q;
    logic signed [NUM_BITS-1:0] x_q    [COEFF_LENGTH];
    logic signed [NUM_BITS-1:0] hcos_q [COEFF_LENGTH];
    logic signed [NUM_BITS-1:0] hsin_q [COEFF_LENGTH];
    logic signed [ACC_W-1:0]    acc_cos_q, acc_sin_q;
    logic signed [NUM_BITS-1:0] cos_q, sin_q;
    logic                       done_q, busy_q, overrun_q, err_q;
    // Old value of an entry overwritten in the same cycle a sample starts,
    // so that sample still computes with the pre-write coefficient.
    logic                       hold_valid_q, hold_sel_q;
    logic [ADDR_W-1:0]          hold_addr_q;
    logic signed [NUM_BITS-1:0] hold_val_q;

    logic                       idle_s, addr_ok_s, tick_take_s, tick_drop_s, wr_ok_s, wr_bad_s;
    logic signed [NUM_BITS-1:0] coef_s;
    logic signed [PROD_W-1:0]   prod_s;

    // Acceptance decode, shared multiplier operand select and next state.
    always_comb begin
        idle_s      = (state_q == ST_IDLE);
        addr_ok_s   = ({1'b0, coeff_addr_i} < LEN_C);
        tick_take_s = idle_s && tick_i;
        tick_drop_s = !idle_s && tick_i;
        wr_ok_s     = coeff_we_i && idle_s && addr_ok_s;
        wr_bad_s    = coeff_we_i && !(idle_s && addr_ok_s);
        if (hold_valid_q && (hold_sel_q == phase_q) && (hold_addr_q == k_q)) begin
            coef_s = hold_val_q;
        end else if (phase_q) begin
            coef_s = hsin_q[k_q];
        end else begin
            coef_s = hcos_q[k_q];
        end
        prod_s = PROD_W'(x_q[k_q]) * PROD_W'(coef_s);
        case (state_q)
            ST_IDLE: begin
                if (tick_take_s) begin
                    state_d = ST_MAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (phase_q && (k_q == LAST_C)) begin
                    state_d = ST_OUTPUT;
                end else begin
                    state_d = ST_MAC;
                end
            end
            ST_OUTPUT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sequencer, sample line, coefficient banks, accumulators and outputs.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            k_q          <= {ADDR_W{1'b0}};
            phase_q      <= 1'b0;
            acc_cos_q    <= {ACC_W{1'b0}};
            acc_sin_q    <= {ACC_W{1'b0}};
            cos_q        <= {NUM_BITS{1'b0}};
            sin_q        <= {NUM_BITS{1'b0}};
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            err_q        <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_sel_q   <= 1'b0;
            hold_addr_q  <= {ADDR_W{1'b0}};
            hold_val_q   <= {NUM_BITS{1'b0}};
            for (int i = 0; i < COEFF_LENGTH; i++) begin
                x_q[i]    <= {NUM_BITS{1'b0}};
                hcos_q[i] <= {NUM_BITS{1'b0}};
                hsin_q[i] <= {NUM_BITS{1'b0}};
            end
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= 1'b0;
            if (tick_drop_s) begin
                overrun_q <= 1'b1;
            end
            if (wr_bad_s) begin
                err_q <= 1'b1;
            end
            if (wr_ok_s) begin
                if (coeff_sel_i) begin
                    hsin_q[coeff_addr_i] <= coeff_data_i;
                end else begin
                    hcos_q[coeff_addr_i] <= coeff_data_i;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (tick_take_s) begin
                        for (int i = COEFF_LENGTH - 1; i > 0; i--) begin
                            x_q[i] <= x_q[i-1];
                        end
                        x_q[0]       <= signal_i;
                        acc_cos_q    <= {ACC_W{1'b0}};
                        acc_sin_q    <= {ACC_W{1'b0}};
                        k_q          <= {ADDR_W{1'b0}};
                        phase_q      <= 1'b0;
                        hold_valid_q <= wr_ok_s;
                        hold_sel_q   <= coeff_sel_i;
                        hold_addr_q  <= coeff_addr_i;
                        hold_val_q   <= coeff_sel_i ? hsin_q[coeff_addr_i] : hcos_q[coeff_addr_i];
                    end
                end
                ST_MAC: begin
                    // Products are sign-extended into the guard bits of the accumulator.
                    if (!phase_q) begin
                        acc_cos_q <= acc_cos_q + {{ADDR_W{prod_s[PROD_W-1]}}, prod_s};
                        phase_q   <= 1'b1;
                    end else begin
                        acc_sin_q <= acc_sin_q + {{ADDR_W{prod_s[PROD_W-1]}}, prod_s};
                        phase_q   <= 1'b0;
                        k_q       <= k_q + ONE_C;
                    end
                end
                ST_OUTPUT: begin
                    cos_q        <= reduce_acc(acc_cos_q);
                    sin_q        <= reduce_acc(acc_sin_q);
                    done_q       <= 1'b1;
                    hold_valid_q <= 1'b0;
                end
                default: hold_valid_q <= 1'b0;
            endcase
        end
    end

    assign cos_o       = cos_q;
    assign sin_o       = sin_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;
    assign coeff_err_o = err_q;

endmodule
